// File: rtl/apb_timer_slave.sv
// APB completer hosting a prescaled down-counting timer with one-shot/auto-reload
// modes, configurable wait states, PSLVERR on bad accesses and a level IRQ.
module apb_timer_slave #(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [7:0]  PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        IRQ
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_LOAD   = 8'h04;
   localparam logic [7:0] ADDR_COUNT  = 8'h08;
   localparam logic [7:0] ADDR_STATUS = 8'h0C;

   typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_e;

   phase_e      phase;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [7:0]  pcnt_q, pcnt_d;
   logic        en_q, en_d;
   logic        auto_reload_q, auto_reload_d;
   logic        irq_en_q, irq_en_d;
   logic [7:0]  prescale_q, prescale_d;
   logic [31:0] load_q, load_d;
   logic [31:0] count_q, count_d;
   logic        expired_q, expired_d;

   logic        ready, bad_access, wr_en, tick;
   logic        sel_ctrl, sel_load, sel_count, sel_status;
   logic [31:0] rd_mux;

   // The bus phase is fully determined by PSEL/PENABLE, so it needs no register.
   always_comb begin
      phase = PH_IDLE;
      if (PSEL && !PENABLE) phase = PH_SETUP;
      if (PSEL && PENABLE)  phase = PH_ACCESS;
   end

   assign sel_ctrl   = (PADDR == ADDR_CTRL);
   assign sel_load   = (PADDR == ADDR_LOAD);
   assign sel_count  = (PADDR == ADDR_COUNT);
   assign sel_status = (PADDR == ADDR_STATUS);

   assign ready      = (phase == PH_ACCESS) && (wcnt_q == WS);
   assign bad_access = !(sel_ctrl || sel_load || sel_count || sel_status) || (PWRITE && sel_count);
   assign wr_en      = ready && PWRITE && !bad_access;
   assign tick       = en_q && (pcnt_q == prescale_q);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      rd_mux = '0;
      if (sel_ctrl)   rd_mux = {16'b0, prescale_q, 5'b0, irq_en_q, auto_reload_q, en_q};
      if (sel_load)   rd_mux = load_q;
      if (sel_count)  rd_mux = count_q;
      if (sel_status) rd_mux = {31'b0, expired_q};
   end

   assign PREADY  = ready;
   assign PSLVERR = ready && bad_access;
   assign PRDATA  = (ready && !PWRITE) ? rd_mux : '0;
   assign IRQ     = expired_q && irq_en_q;

   // Dropping PSEL mid-access also lands here and abandons the wait count.
   always_comb begin
      wcnt_d = '0;
      if (phase == PH_ACCESS && !ready) wcnt_d = wcnt_q + 4'd1;
   end

   // Priority is by statement order: W1C before the hardware set, bus writes last.
   always_comb begin
      en_d          = en_q;
      auto_reload_d = auto_reload_q;
      irq_en_d      = irq_en_q;
      prescale_d    = prescale_q;
      load_d        = load_q;
      count_d       = count_q;
      expired_d     = expired_q;
      pcnt_d        = (!en_q || tick) ? 8'd0 : pcnt_q + 8'd1;

      if (wr_en && sel_status && PWDATA[0]) expired_d = 1'b0;

      if (tick) begin
         if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
         end else begin
            expired_d = 1'b1;
            if (auto_reload_q) count_d = load_q;
            else               en_d    = 1'b0;
         end
      end

      if (wr_en && sel_load) begin
         load_d  = PWDATA;
         count_d = PWDATA;
      end

      if (wr_en && sel_ctrl) begin
         en_d          = PWDATA[0];
         auto_reload_d = PWDATA[1];
         irq_en_d      = PWDATA[2];
         prescale_d    = PWDATA[15:8];
         pcnt_d        = 8'd0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         wcnt_q        <= '0;
         pcnt_q        <= '0;
         en_q          <= 1'b0;
         auto_reload_q <= 1'b0;
         irq_en_q      <= 1'b0;
         prescale_q    <= '0;
         load_q        <= '0;
         count_q       <= '0;
         expired_q     <= 1'b0;
      end else begin
         wcnt_q        <= wcnt_d;
         pcnt_q        <= pcnt_d;
         en_q          <= en_d;
         auto_reload_q <= auto_reload_d;
         irq_en_q      <= irq_en_d;
         prescale_q    <= prescale_d;
         load_q        <= load_d;
         count_q       <= count_d;
         expired_q     <= expired_d;
      end
   end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave: three instances with 0, 3 and 2 wait states
// share one APB bus and are selected individually through PSEL.
module tb_apb_timer_slave;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic [2:0]  psel = '0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [7:0]  paddr = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata [3];
   logic        pready [3];
   logic        pslverr [3];
   logic        irq [3];

   int checks = 0;
   int errors = 0;

   always #5 PCLK = ~PCLK;

   apb_timer_slave #(.WAIT_STATES(0)) dut_ws0 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
      .PSLVERR(pslverr[0]), .IRQ(irq[0]));

   apb_timer_slave #(.WAIT_STATES(3)) dut_ws3 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
      .PSLVERR(pslverr[1]), .IRQ(irq[1]));

   apb_timer_slave #(.WAIT_STATES(2)) dut_ws2 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]),
      .PSLVERR(pslverr[2]), .IRQ(irq[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge; returns just after the completing edge so
   // transfers can be issued back to back (SETUP directly after ACCESS).
   task automatic apb(input int idx, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int waits, output logic leak);
      psel    = 3'b001 << idx;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      waits   = 0;
      leak    = 1'b0;
      @(posedge PCLK);
      #1 penable = 1'b1;
      @(negedge PCLK);
      while (!pready[idx] && waits < 32) begin
         if (prdata[idx] != 32'd0 || pslverr[idx]) leak = 1'b1;
         waits++;
         @(negedge PCLK);
      end
      if (!pready[idx]) check("bus_timeout", {31'b0, pready[idx]}, 32'd1);
      rdata = prdata[idx];
      err   = pslverr[idx];
      @(posedge PCLK);
      #1;
      psel    = '0;
      penable = 1'b0;
   endtask

   task automatic wr_chk(input int idx, input logic [7:0] addr, input logic [31:0] data,
                         input logic exp_err, input string tag);
      logic [31:0] rd;
      logic        err, lk;
      int          w;
      apb(idx, 1'b1, addr, data, rd, err, w, lk);
      check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
   endtask

   task automatic rd_chk(input int idx, input logic [7:0] addr, input logic [31:0] exp_data,
                         input logic exp_err, input string tag);
      logic [31:0] rd;
      logic        err, lk;
      int          w;
      apb(idx, 1'b0, addr, 32'd0, rd, err, w, lk);
      check({tag, "_data"}, rd, exp_data);
      check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        err, lk;
      int          w;

      // Reset state
      repeat (2) @(posedge PCLK);
      #1;
      check("rst_prdata", prdata[0], 32'd0);
      check("rst_pready", {31'b0, pready[0]}, 32'd0);
      check("rst_pslverr", {31'b0, pslverr[0]}, 32'd0);
      check("rst_irq", {31'b0, irq[0]}, 32'd0);
      PRESET = 1'b0;
      @(posedge PCLK);
      #1;

      // Zero wait states: LOAD write copies into COUNT
      apb(0, 1'b1, 8'h04, 32'h5, rd, err, w, lk);
      check("ws0_wr_waits", 32'(w), 32'd0);
      check("ws0_wr_err", {31'b0, err}, 32'd0);
      apb(0, 1'b0, 8'h08, 32'd0, rd, err, w, lk);
      check("ws0_rd_count", rd, 32'h5);
      check("ws0_rd_err", {31'b0, err}, 32'd0);
      check("ws0_rd_waits", 32'(w), 32'd0);

      // Three wait states, no data or error leaking before PREADY
      apb(1, 1'b0, 8'h00, 32'd0, rd, err, w, lk);
      check("ws3_rd_waits", 32'(w), 32'd3);
      check("ws3_rd_data", rd, 32'd0);
      check("ws3_rd_leak", {31'b0, lk}, 32'd0);
      apb(1, 1'b1, 8'h04, 32'hA5A5_0001, rd, err, w, lk);
      check("ws3_wr_waits", 32'(w), 32'd3);
      rd_chk(1, 8'h04, 32'hA5A5_0001, 1'b0, "ws3_rd_load");

      // One-shot, PRESCALE 0: ticks on every edge after enable (E0).
      wr_chk(0, 8'h04, 32'd3, 1'b0, "os_load");
      wr_chk(0, 8'h00, 32'h1, 1'b0, "os_ctrl");
      rd_chk(0, 8'h08, 32'd2, 1'b0, "os_count_e1");
      rd_chk(0, 8'h0C, 32'd0, 1'b0, "os_status_e3");
      rd_chk(0, 8'h0C, 32'd1, 1'b0, "os_status_e5");
      rd_chk(0, 8'h00, 32'd0, 1'b0, "os_ctrl_en_cleared");
      rd_chk(0, 8'h08, 32'd0, 1'b0, "os_count_stays0");
      check("os_irq_masked", {31'b0, irq[0]}, 32'd0);
      wr_chk(0, 8'h0C, 32'h1, 1'b0, "os_w1c");
      rd_chk(0, 8'h0C, 32'd0, 1'b0, "os_status_cleared");

      // Auto-reload, PRESCALE 2, LOAD 1: expiries at E6, E12, E18 after enable
      wr_chk(0, 8'h04, 32'd1, 1'b0, "ar_load");
      wr_chk(0, 8'h00, 32'h0207, 1'b0, "ar_ctrl");
      repeat (5) @(posedge PCLK);
      @(negedge PCLK);
      check("ar_irq_e5", {31'b0, irq[0]}, 32'd0);
      @(posedge PCLK);
      @(negedge PCLK);
      check("ar_irq_e6", {31'b0, irq[0]}, 32'd1);
      @(posedge PCLK);
      #1;
      rd_chk(0, 8'h08, 32'd1, 1'b0, "ar_count_reloaded");
      wr_chk(0, 8'h0C, 32'h1, 1'b0, "ar_w1c");
      @(negedge PCLK);
      check("ar_irq_after_w1c", {31'b0, irq[0]}, 32'd0);
      @(posedge PCLK);
      @(negedge PCLK);
      check("ar_irq_e12", {31'b0, irq[0]}, 32'd1);
      repeat (4) @(posedge PCLK);
      #1;
      // W1C completes at E18, the same edge as the next hardware set
      wr_chk(0, 8'h0C, 32'h1, 1'b0, "ar_w1c_collide");
      @(negedge PCLK);
      check("ar_set_wins", {31'b0, irq[0]}, 32'd1);
      @(posedge PCLK);
      #1;
      wr_chk(0, 8'h00, 32'h0, 1'b0, "ar_disable");
      wr_chk(0, 8'h0C, 32'h1, 1'b0, "ar_w1c_final");
      check("ar_irq_off", {31'b0, irq[0]}, 32'd0);

      // Error responses
      wr_chk(0, 8'h04, 32'h5, 1'b0, "er_load");
      wr_chk(0, 8'h08, 32'hFF, 1'b1, "er_wr_count");
      rd_chk(0, 8'h08, 32'h5, 1'b0, "er_count_kept");
      rd_chk(0, 8'h10, 32'd0, 1'b1, "er_rd_bad_addr");
      wr_chk(0, 8'h10, 32'hFFFF_FFFF, 1'b1, "er_wr_bad_addr");
      rd_chk(0, 8'h00, 32'd0, 1'b0, "er_ctrl_kept");
      rd_chk(0, 8'h04, 32'h5, 1'b0, "er_load_kept");

      // Reset in the completing ACCESS cycle of a LOAD write (2 wait states)
      psel    = 3'b100;
      pwrite  = 1'b1;
      paddr   = 8'h04;
      pwdata  = 32'hDEAD_BEEF;
      penable = 1'b0;
      @(posedge PCLK);
      #1 penable = 1'b1;
      repeat (2) @(posedge PCLK);
      #1;
      check("rst_mid_pready_before", {31'b0, pready[2]}, 32'd1);
      #2 PRESET = 1'b1;
      #1;
      check("rst_mid_pready_drop", {31'b0, pready[2]}, 32'd0);
      @(posedge PCLK);
      #1;
      psel    = '0;
      penable = 1'b0;
      PRESET  = 1'b0;
      @(posedge PCLK);
      #1;
      apb(2, 1'b0, 8'h04, 32'd0, rd, err, w, lk);
      check("rst_mid_load", rd, 32'd0);
      check("rst_mid_waits", 32'(w), 32'd2);
      rd_chk(0, 8'h04, 32'd0, 1'b0, "rst_ws0_load");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
